// File: rtl/add_arb_seq_pkg.sv
// Shared types and defaults for the two-requester multi-pass adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_arb_seq_pkg;

  localparam int LANE_W_DEF = 32;
  localparam int LANES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add_arb_seq_if.sv
// Request/response bundle between two requesters, one consumer and the adder.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the result.
interface add_arb_seq_if
  import add_arb_seq_pkg::*;
#(
  parameter int OPW = LANE_W_DEF * LANES_DEF
);

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [OPW-1:0] req_a0;
  logic [OPW-1:0] req_b0;
  logic [OPW-1:0] req_a1;
  logic [OPW-1:0] req_b1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [OPW-1:0] rsp_sum;
  logic           rsp_cout;
  logic           rsp_id;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/add_arb_seq_add_lane.sv
// One LANE_W-bit adder pass with carry-in/out, parallel-prefix carry tree.
// Latency: purely combinational.
// Backpressure: none.
module add_lane #(
  parameter int LANE_W = 32
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  output logic [LANE_W-1:0] sum,
  output logic              cout
);

  logic [LANE_W-1:0] g;
  logic [LANE_W-1:0] p;
  logic [LANE_W-1:0] grp_g;
  logic [LANE_W-1:0] grp_p;
  logic [LANE_W:0]   c;

  // Kogge-Stone prefix: after the loop grp_g/grp_p[i] span bits 0..i.
  // Walking i downward keeps lower entries at the previous level's value.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    grp_g = g;
    grp_p = p;
    for (int d = 1; d < LANE_W; d = d * 2) begin
      for (int i = LANE_W - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < LANE_W; i++) begin
      c[i+1] = grp_g[i] | (grp_p[i] & cin);
    end
    sum  = p ^ c[LANE_W-1:0];
    cout = c[LANE_W];
  end

endmodule

// File: rtl/add_arb_seq.sv
// Round-robin arbiter feeding a wide adder that reuses one lane adder over LANES passes.
// Latency: handshake at edge k -> rsp_valid in the cycle after edge k+LANES.
// Backpressure: no grant outside IDLE; result held in RESP until rsp_ready.
module add_arb_seq
  import add_arb_seq_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  add_arb_seq_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int OPW = LANE_W * LANES;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0]    S_IDLE    = IDLE;
  localparam logic [1:0]    S_RUN     = RUN;
  localparam logic [1:0]    S_RESP    = RESP;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [1:0]        state;
  logic              rr;
  logic [LW-1:0]     lane;
  logic              carry;
  logic              op_id;
  logic [LANE_W-1:0] op_a [LANES];
  logic [LANE_W-1:0] op_b [LANES];
  logic [LANE_W-1:0] res  [LANES];
  logic [LANE_W-1:0] in_a [LANES];
  logic [LANE_W-1:0] in_b [LANES];

  logic [1:0]        grant;
  logic              gnt_id;
  logic              hs;
  logic [OPW-1:0]    src_a;
  logic [OPW-1:0]    src_b;
  logic [OPW-1:0]    sum_flat;
  logic [LANE_W-1:0] lane_sum;
  logic              lane_cout;

  // Grant only in IDLE: the pointed-to requester wins, else the other one.
  always_comb begin
    grant = 2'b00;
    if (state == S_IDLE) begin
      if (bus.req_valid[rr]) begin
        grant[rr] = 1'b1;
      end else if (bus.req_valid[~rr]) begin
        grant[~rr] = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign gnt_id        = grant[1];
  assign hs            = |grant;
  assign src_a         = gnt_id ? bus.req_a1 : bus.req_a0;
  assign src_b         = gnt_id ? bus.req_b1 : bus.req_b0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_slice
    assign in_a[gi]                       = src_a[gi*LANE_W +: LANE_W];
    assign in_b[gi]                       = src_b[gi*LANE_W +: LANE_W];
    assign sum_flat[gi*LANE_W +: LANE_W]  = res[gi];
  end

  add_lane #(.LANE_W(LANE_W)) u_add_lane (
    .a    (op_a[lane]),
    .b    (op_b[lane]),
    .cin  (carry),
    .sum  (lane_sum),
    .cout (lane_cout)
  );

  // Capture on grant, one lane per RUN cycle, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr       <= 1'b0;
      lane     <= '0;
      carry    <= 1'b0;
      op_id    <= 1'b0;
      done_cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            for (int i = 0; i < LANES; i++) begin
              op_a[i] <= in_a[i];
              op_b[i] <= in_b[i];
            end
            op_id <= gnt_id;
            lane  <= '0;
            carry <= 1'b0;
            rr    <= ~gnt_id;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res[lane] <= lane_sum;
          carry     <= lane_cout;
          if (lane == LAST_LANE) begin
            state <= S_RESP;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state    <= S_IDLE;
            done_cnt <= done_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_sum   = bus.rsp_valid ? sum_flat : '0;
  assign bus.rsp_cout  = bus.rsp_valid ? carry : 1'b0;
  assign bus.rsp_id    = bus.rsp_valid ? op_id : 1'b0;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_add_arb_seq.sv
// Self-checking bench: directed vectors, stall/reset corner cases, random run vs model.
// Latency: checks LANES-pass response timing.
// Backpressure: exercises rsp_ready stalls and concurrent requests.
module tb_add_arb_seq;

  localparam int LANES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_arb_seq_if #(.OPW(64)) ifc ();
  logic        busy;
  logic [15:0] done_cnt;

  add_arb_seq #(.LANE_W(32), .LANES(LANES), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  // Narrow instance: 4 passes of 4 bits and a 4-bit counter to reach the wrap quickly.
  add_arb_seq_if #(.OPW(16)) ifc2 ();
  logic       busy2;
  logic [3:0] done2;

  add_arb_seq #(.LANE_W(4), .LANES(4), .CNT_W(4)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc2),
    .busy     (busy2),
    .done_cnt (done2)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_done = 16'd0;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] a0, b0, a1, b1;
    logic        exp_id;
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    case ($urandom % 4)
      0:       v = 64'h0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h0000_0000_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Called at posedge+1. Runs one operation, checks grant, latency, result, stall hold and count.
  task automatic run_op(input string tag, input logic [1:0] v,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1,
                        input logic eid, input logic [63:0] esum, input logic ecout,
                        input int stall);
    int n;
    int lat;
    ifc.req_valid = v;
    ifc.req_a0    = a0;
    ifc.req_b0    = b0;
    ifc.req_a1    = a1;
    ifc.req_b1    = b1;
    ifc.rsp_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (ifc.req_ready == 2'b00 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_grant"}, ifc.req_ready, eid ? 2'b10 : 2'b01);
    @(posedge clk);
    #1;
    ifc.req_valid = 2'b00;
    ifc.req_a0    = ~a0;
    ifc.req_b0    = {$urandom, $urandom};
    ifc.req_a1    = ~a1;
    ifc.req_b1    = {$urandom, $urandom};
    lat = 0;
    @(negedge clk);
    while (!ifc.rsp_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, LANES);
    chk({tag, "_result"}, {ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum}, {eid, ecout, esum});
    if (stall > 0) begin
      ifc.req_valid = 2'b11;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, "_hold"}, {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum},
            {1'b1, eid, ecout, esum});
        chk({tag, "_noready"}, ifc.req_ready, 2'b00);
        chk({tag, "_cnt_hold"}, done_cnt, exp_done);
      end
      ifc.req_valid = 2'b00;
      ifc.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_done = exp_done + 16'd1;
    chk({tag, "_after"}, {ifc.rsp_valid, ifc.rsp_cout, ifc.rsp_sum, done_cnt},
        {1'b0, 1'b0, 64'h0, exp_done});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_done = 16'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          gq [$];
    int          low;
    int          maxlow;
    int          bad;
    int          n;
    int          lat;
    logic        rr_m;
    int          m_wait;
    logic [15:0] m_done;
    logic [1:0]  exp_rdy;
    logic        m_id;
    logic [64:0] m_res;
    logic [15:0] wa, wb;
    logic [16:0] wt;

    vecs[0] = '{2'b01, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h1234, 64'h1,
                1'b0, 64'h0000_0001_0000_0000, 1'b0};
    vecs[1] = '{2'b10, 64'h5555, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                1'b1, 64'h0, 1'b1};
    vecs[2] = '{2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h5, 64'h6,
                1'b0, 64'h0, 1'b1};
    vecs[3] = '{2'b11, 64'h9, 64'h9, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
                1'b1, 64'h1234_5678_9ABC_DF00, 1'b0};
    vecs[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
                1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};

    ifc.req_valid  = 2'b00;
    ifc.req_a0     = '0;
    ifc.req_b0     = '0;
    ifc.req_a1     = '0;
    ifc.req_b1     = '0;
    ifc.rsp_ready  = 1'b1;
    ifc2.req_valid = 2'b00;
    ifc2.req_a0    = '0;
    ifc2.req_b0    = '0;
    ifc2.req_a1    = '0;
    ifc2.req_b1    = '0;
    ifc2.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ifc.rsp_valid, ifc.rsp_cout, ifc.rsp_id, ifc.rsp_sum, busy, ifc.req_ready},
        '0);
    chk("reset_done_cnt", done_cnt, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1,
             vecs[i].b1, vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_cout, 0);
    end

    run_op("stall", 2'b01, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h3, 64'h4,
           1'b0, 64'h0000_0001_0000_0000, 1'b0, 5);

    // Both requesters held from reset: alternating grants, IDLE lasts one cycle.
    rst_n         = 1'b0;
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    low    = 0;
    maxlow = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.req_ready != 2'b00) gq.push_back(int'(ifc.req_ready[1]));
      if (!busy) begin
        low++;
        if (low > maxlow) maxlow = low;
      end else begin
        low = 0;
      end
    end
    chk("rr_grants", gq.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (gq.size() > i) chk($sformatf("rr_order%0d", i), gq[i], i % 2);
    end
    chk("busy_gap", maxlow <= 1, 1'b1);
    @(posedge clk);
    #1;
    ifc.req_valid = 2'b00;

    // Reset in the middle of RUN drops the operation and clears the pointer.
    do_reset();
    run_op("pre_rst", 2'b01, 64'h10, 64'h20, 64'h0, 64'h0, 1'b0, 64'h30, 1'b0, 0);
    ifc.req_valid = 2'b11;
    @(negedge clk);
    chk("pre_rst_grant", ifc.req_ready, 2'b10);
    @(posedge clk);
    #1;
    ifc.req_valid = 2'b00;
    @(negedge clk);
    chk("run_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", {ifc.rsp_valid, ifc.rsp_cout, ifc.rsp_id, ifc.rsp_sum, busy, ifc.req_ready},
        '0);
    chk("rst_run_done_cnt", done_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_done = 16'd0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_no_rsp", bad, 0);
    @(posedge clk);
    #1;
    run_op("post_rst", 2'b11, 64'h7, 64'h8, 64'h100, 64'h200, 1'b0, 64'hF, 1'b0, 0);

    // Random traffic checked cycle by cycle against a countdown/scoreboard model.
    do_reset();
    rr_m   = 1'b0;
    m_wait = -1;
    m_done = 16'd0;
    m_id   = 1'b0;
    m_res  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ifc.req_valid = {($urandom % 3) != 0, ($urandom % 3) != 0};
      ifc.req_a0    = rnd_op();
      ifc.req_b0    = rnd_op();
      ifc.req_a1    = rnd_op();
      ifc.req_b1    = rnd_op();
      ifc.rsp_ready = ($urandom % 2) != 0;
      @(negedge clk);
      exp_rdy = 2'b00;
      if (m_wait < 0) begin
        if (ifc.req_valid[rr_m])       exp_rdy[rr_m]  = 1'b1;
        else if (ifc.req_valid[!rr_m]) exp_rdy[!rr_m] = 1'b1;
      end
      chk("rnd_ready", ifc.req_ready, exp_rdy);
      chk("rnd_busy", busy, m_wait >= 0);
      chk("rnd_valid", ifc.rsp_valid, m_wait == 0);
      if (m_wait == 0) chk("rnd_result", {ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum}, {m_id, m_res});
      else             chk("rnd_zero", {ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum}, '0);
      chk("rnd_done_cnt", done_cnt, m_done);
      if (m_wait < 0 && exp_rdy != 2'b00) begin
        m_id   = exp_rdy[1];
        m_res  = m_id ? ({1'b0, ifc.req_a1} + {1'b0, ifc.req_b1})
                      : ({1'b0, ifc.req_a0} + {1'b0, ifc.req_b0});
        rr_m   = !m_id;
        m_wait = LANES;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_wait == 0 && ifc.rsp_ready) begin
        m_done = m_done + 16'd1;
        m_wait = -1;
      end
      @(posedge clk);
      #1;
    end
    ifc.req_valid = 2'b00;

    // Narrow instance: sixteen operations wrap the 4-bit completion counter.
    do_reset();
    ifc2.rsp_ready = 1'b1;
    for (int op = 0; op < 16; op++) begin
      wa = (op == 0) ? 16'hFFFF : 16'($urandom);
      wb = (op == 0) ? 16'h0001 : 16'($urandom);
      ifc2.req_valid = 2'b01;
      ifc2.req_a0    = wa;
      ifc2.req_b0    = wb;
      n = 0;
      @(negedge clk);
      while (!ifc2.req_ready[0] && n < 10) begin
        n++;
        @(negedge clk);
      end
      chk("w_grant", ifc2.req_ready, 2'b01);
      @(posedge clk);
      #1;
      ifc2.req_valid = 2'b00;
      ifc2.req_a0    = ~wa;
      lat = 0;
      @(negedge clk);
      while (!ifc2.rsp_valid && lat < 20) begin
        lat++;
        @(negedge clk);
      end
      chk("w_latency", lat, 4);
      wt = {1'b0, wa} + {1'b0, wb};
      chk("w_result", {ifc2.rsp_cout, ifc2.rsp_sum}, wt);
      @(posedge clk);
      #1;
      if (op == 14) chk("w_cnt15", done2, 4'hF);
    end
    chk("w_wrap", done2, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
